// File: rtl/capture_timer_pkg.sv
// Shared types and default widths for the input-capture timer.
package capture_timer_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int PSC_W_DEF = 5;

  typedef enum logic [1:0] {
    CT_IDLE,
    CT_ARM,
    CT_RUN
  } ct_state_e;

endpackage

// File: rtl/capture_prescaler.sv
// Prescaler for the capture timer: emits a one-clock tick every psc+1 clocks
// while running. A capture edge restarts the count so every period is timed
// from the same phase. A psc change applies at the next compare; if pre is
// already past the new value it counts on through the wrap before ticking.
module capture_prescaler #(
  parameter int PSC_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [PSC_W-1:0] psc_i,
  output logic             tick_o
);

  logic [PSC_W-1:0] pre_q, pre_d;

  assign tick_o = run_i & (pre_q == psc_i);

  // Next prescale count: parked at zero outside RUN, restart on tick or edge.
  always_comb begin
    pre_d = pre_q + 1'b1;
    if (!run_i || tick_o || clr_i) pre_d = '0;
  end

  // Prescale count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/capture_timer.sv
// Prescaled input-capture timer. Synchronises cap_in, counts prescaler ticks
// between successive rising edges and hands each period to the consumer over
// valid/ready. The first edge after enabling only arms the counter.
// Optional build macro CAPTURE_FILTER_EN adds a 3-sample glitch filter after
// the synchroniser (pulses shorter than 3 clk are ignored, latency +2 clk).
module capture_timer
  import capture_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic             cap_in,
  output logic             tick,
  output logic [CNT_W-1:0] cap_data,
  output logic             cap_ovf,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic             overrun
);

  localparam logic [CNT_W:0] SAT_VAL = {1'b0, {CNT_W{1'b1}}};

  ct_state_e        state_q;
  logic             s1_q, s2_q, s3_q;
  logic             lvl_d;
  logic             cap_edge;
  logic             run;
  logic             cap_evt, load, accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W:0]   sum;
  logic             sum_sat;
  logic [CNT_W-1:0] sum_clip;
  logic [CNT_W-1:0] cap_data_d;
  logic             cap_ovf_q, cap_ovf_d;
  logic             cap_valid_q, cap_valid_d;
  logic             overrun_q, overrun_d;

  // ---------------- input path ----------------
`ifdef CAPTURE_FILTER_EN
  logic flt_a_q, flt_b_q;

  // Filtered level only moves once three consecutive samples agree.
  always_comb begin
    lvl_d = s3_q;
    if ((s2_q == flt_a_q) && (flt_a_q == flt_b_q)) lvl_d = s2_q;
  end

  // Sample history for the glitch filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_a_q <= 1'b0;
      flt_b_q <= 1'b0;
    end else begin
      flt_a_q <= s2_q;
      flt_b_q <= flt_a_q;
    end
  end
`else
  assign lvl_d = s2_q;
`endif

  // Two-flop synchroniser plus a delayed copy of the level for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= cap_in;
      s2_q <= s1_q;
      s3_q <= lvl_d;
    end
  end

  assign cap_edge = lvl_d & ~s3_q;

  // ---------------- control ----------------
  // Mode FSM: disable drops straight to IDLE from anywhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CT_IDLE;
    else if (!en) state_q <= CT_IDLE;
    else begin
      case (state_q)
        CT_IDLE: state_q <= CT_ARM;
        CT_ARM:  if (cap_edge) state_q <= CT_RUN;
        CT_RUN:  state_q <= CT_RUN;
        default: state_q <= CT_IDLE;
      endcase
    end
  end

  assign run = en & (state_q == CT_RUN);

  capture_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk   (clk),
    .reset (reset),
    .run_i (run),
    .clr_i (cap_edge),
    .psc_i (psc),
    .tick_o(tick)
  );

  // ---------------- period counter ----------------
  // The tick of the edge cycle still belongs to the period being closed.
  assign sum      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, tick};
  assign sum_sat  = (sum >= SAT_VAL);
  assign sum_clip = sum_sat ? SAT_VAL[CNT_W-1:0] : sum[CNT_W-1:0];

  assign cap_evt = run & cap_edge;
  assign accept  = cap_valid_q & cap_ready;
  assign load    = cap_evt & (~cap_valid_q | cap_ready);

  // Counter next state: restart on edge, saturating count on tick.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (!run || cap_edge) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (tick) begin
      cnt_d = sum_clip;
      sat_d = sat_q | sum_sat;
    end
  end

  // Capture / handshake next state; a held result is never overwritten.
  always_comb begin
    cap_data_d  = cap_data;
    cap_ovf_d   = cap_ovf_q;
    cap_valid_d = cap_valid_q;
    overrun_d   = overrun_q;
    if (load) begin
      cap_data_d  = sum_clip;
      cap_ovf_d   = sat_q | sum_sat;
      cap_valid_d = 1'b1;
    end else if (accept) begin
      cap_valid_d = 1'b0;
    end
    if (!en) overrun_d = 1'b0;
    else if (cap_evt && cap_valid_q && !cap_ready) overrun_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      cap_data    <= '0;
      cap_ovf_q   <= 1'b0;
      cap_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      cap_data    <= cap_data_d;
      cap_ovf_q   <= cap_ovf_d;
      cap_valid_q <= cap_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cap_ovf   = cap_ovf_q;
  assign cap_valid = cap_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_capture_timer.sv
// Bench for capture_timer: table of edge-train vectors with a scoreboard of
// expected captures, plus hand sequences for tick spacing, overrun/hold and
// asynchronous reset.
module tb_capture_timer;
  import capture_timer_pkg::*;

  localparam int CNT_W = 16;
  localparam int PSC_W = 5;
`ifdef CAPTURE_FILTER_EN
  localparam int LAT_X = 2;
`else
  localparam int LAT_X = 0;
`endif

  logic             clk = 1'b0;
  logic             reset, en, cap_in, cap_ready;
  logic [PSC_W-1:0] psc;
  logic             tick, cap_ovf, cap_valid, overrun;
  logic [CNT_W-1:0] cap_data;

  typedef struct {
    bit          rearm;
    int          psc;
    int          period;
    int          nper;
    logic [15:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   nvec = 0;
  int   nerr = 0;

  capture_timer dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .psc      (psc),
    .cap_in   (cap_in),
    .tick     (tick),
    .cap_data (cap_data),
    .cap_ovf  (cap_ovf),
    .cap_valid(cap_valid),
    .cap_ready(cap_ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  // Disable, then re-enable and raise cap_in while in ARM (arming edge).
  task automatic rearm(input int p, input logic rdy);
    cap_in = 1'b0;
    en     = 1'b0;
    step(4);
    en        = 1'b1;
    psc       = PSC_W'(p);
    cap_ready = rdy;
    step(1);
    cap_in = 1'b1;
  endtask

  // Scoreboard consumer: every accepted transfer must match the next expectation.
  always @(negedge clk) begin
    if (!reset && cap_valid && cap_ready) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_capture: got data %0h ovf %0b, none expected", cap_data, cap_ovf);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cap_data", 32'(cap_data), 32'(e.data));
        check("cap_ovf", 32'(cap_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    logic [31:0] pat, exp_pat;
    int last;

    tbl[0] = '{1'b1, 0, 10,    3, 16'd10,   1'b0};
    tbl[1] = '{1'b0, 0, 25,    2, 16'd25,   1'b0};
    tbl[2] = '{1'b1, 3, 40,    2, 16'd10,   1'b0};
    tbl[3] = '{1'b1, 1, 21,    2, 16'd10,   1'b0};
    tbl[4] = '{1'b1, 4, 52,    2, 16'd10,   1'b0};
    tbl[5] = '{1'b1, 0, 70000, 1, 16'hFFFF, 1'b1};
    tbl[6] = '{1'b0, 0, 10,    2, 16'd10,   1'b0};

    // Reset state, with inputs that would otherwise make tick active.
    reset = 1'b1; en = 1'b1; psc = '0; cap_in = 1'b0; cap_ready = 1'b1;
    step(3);
    check("reset_outputs", {11'd0, tick, cap_valid, cap_ovf, overrun, cap_data}, 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(CT_IDLE));
    reset = 1'b0;
    step(2);

    // Tick spacing with psc=3: RUN starts 2 clk after the arming drive.
    rearm(3, 1'b1);
    pat = '0; exp_pat = '0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      pat[i] = tick;
      if (i >= 3 + LAT_X && ((i - 2 - LAT_X) % 4) == 0) exp_pat[i] = 1'b1;
    end
    check("tick_pattern_psc3", pat, exp_pat);

    // Table-driven edge trains.
    last = 6;
    for (int i = 0; i <= last; i++) begin
      if (tbl[i].rearm) rearm(tbl[i].psc, 1'b1);
      for (int k = 0; k < tbl[i].nper; k++) begin
        step(tbl[i].period / 2);
        cap_in = 1'b0;
        step(tbl[i].period - tbl[i].period / 2);
        cap_in = 1'b1;
        push(tbl[i].exp_data, tbl[i].exp_ovf);
      end
      if (i == last || tbl[i + 1].rearm) begin
        step(8);
        check("drained", 32'(sb.size()), 32'd0);
        check("no_overrun", 32'(overrun), 32'd0);
      end
    end

    // Back-pressure: second edge captured and held, third dropped.
    rearm(0, 1'b0);
    step(5); cap_in = 1'b0; step(5); cap_in = 1'b1;
    push(16'd10, 1'b0);
    step(5); cap_in = 1'b0; step(5); cap_in = 1'b1;
    step(5);
    cap_in = 1'b0;
    check("held_valid", 32'(cap_valid), 32'd1);
    check("held_data", 32'(cap_data), 32'd10);
    check("overrun_set", 32'(overrun), 32'd1);
    cap_ready = 1'b1;
    step(1);
    cap_ready = 1'b0;
    check("valid_cleared", 32'(cap_valid), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-run with a result pending.
    step(2);
    cap_in = 1'b1;
    step(6);
    check("pending_valid", 32'(cap_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("midrun_reset_outputs", {11'd0, tick, cap_valid, cap_ovf, overrun, cap_data}, 32'd0);
    check("midrun_reset_state", 32'(dut.state_q), 32'(CT_IDLE));
    step(2);
    reset = 1'b0;
    cap_in = 1'b0;
    step(2);

`ifdef CAPTURE_FILTER_EN
    // A 2-clk glitch inside a low phase must not end the period.
    rearm(0, 1'b1);
    step(3); cap_in = 1'b0;
    step(4); cap_in = 1'b1;
    step(2); cap_in = 1'b0;
    step(11); cap_in = 1'b1;
    push(16'd20, 1'b0);
    step(5); cap_in = 1'b0;
    step(5); cap_in = 1'b1;
    push(16'd10, 1'b0);
    step(10);
    check("filter_drained", 32'(sb.size()), 32'd0);
`endif

    step(4);
    check("final_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
